ahb_slave_mem: RTL

- AHB-lite responder (slave) memory terminating transfers issued by the bus master that executes decoded instruction words (WRITE, BURST, SEL, ADDR, DATA).
- One instance per HSEL line.
- Stores 8-bit data at 10-bit addresses.
- Timing:
  - Writes complete in 2 clocks: address phase + zero-wait data phase.
  - Reads complete in 5 clocks: address phase + READ_WAIT wait states + data phase.
- Out-of-range accesses get the AHB two-cycle ERROR response.

---
 rtl/ahb_slave_mem.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-lite responder backed by a DEPTH x DATA_W memory: zero-wait writes,
// READ_WAIT-stalled NONSEQ reads, a one-word prefetch for SEQ beats, ERROR for out-of-range.
module ahb_slave_mem #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned READ_WAIT = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_RWAIT, S_RDATA, S_ERR1, S_ERR2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, pf_addr_q, pf_addr_d;
  logic [DATA_W-1:0] pf_data_q, pf_data_d, hrdata_q, hrdata_d;
  logic              pf_valid_q, pf_valid_d, incr_q, incr_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              hreadyout_q, hreadyout_d, hresp_q, hresp_d;

  logic              accept, oor;
  logic [ADDR_W-1:0] addr_inc;

  assign accept   = (state_q inside {S_IDLE, S_WDATA, S_RDATA}) && HSEL && HREADY && HTRANS[1];
  assign oor      = {1'b0, HADDR} >= (ADDR_W+1)'(DEPTH);
  assign addr_inc = addr_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    incr_d     = incr_q;
    wcnt_d     = wcnt_q;
    hrdata_d   = hrdata_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;

    case (state_q)
      S_RWAIT: begin
        if (wcnt_q == '0) begin
          state_d  = S_RDATA;
          hrdata_d = mem[addr_q[MEM_AW-1:0]];
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      S_ERR2: begin
        state_d    = S_IDLE;
        pf_valid_d = 1'b0;
      end
      default: begin
        // pf_*_d already carry this cycle's refill, so a SEQ beat pipelined
        // behind a read data phase can hit the word being prefetched now.
        if (state_q == S_RDATA) begin
          pf_addr_d  = addr_inc;
          pf_data_d  = mem[addr_inc[MEM_AW-1:0]];
          pf_valid_d = incr_q;
        end
        state_d = S_IDLE;
        if (accept) begin
          addr_d = HADDR;
          incr_d = (HBURST != 3'b000);
          if (oor) begin
            state_d    = S_ERR1;
            pf_valid_d = 1'b0;
          end else if (HWRITE) begin
            state_d    = S_WDATA;
            pf_valid_d = 1'b0;
          end else if (HTRANS[0] && pf_valid_d && (HADDR == pf_addr_d)) begin
            state_d  = S_RDATA;
            hrdata_d = pf_data_d;
          end else begin
            if (!HTRANS[0]) pf_valid_d = 1'b0;
            if (READ_WAIT > 0) begin
              state_d = S_RWAIT;
              wcnt_d  = 3'(READ_WAIT - 1);
            end else begin
              // Zero-wait read behind a write to the same word sees the write data.
              state_d  = S_RDATA;
              hrdata_d = (state_q == S_WDATA && addr_q == HADDR) ? HWDATA
                                                                 : mem[HADDR[MEM_AW-1:0]];
            end
          end
        end else if (HREADY && (!HSEL || HTRANS == 2'b00)) begin
          pf_valid_d = 1'b0;
        end
      end
    endcase

    case (state_d)
      S_RWAIT: begin hreadyout_d = 1'b0; hresp_d = 1'b0; end
      S_ERR1:  begin hreadyout_d = 1'b0; hresp_d = 1'b1; end
      S_ERR2:  begin hreadyout_d = 1'b1; hresp_d = 1'b1; end
      default: begin hreadyout_d = 1'b1; hresp_d = 1'b0; end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      incr_q      <= 1'b0;
      wcnt_q      <= '0;
      hrdata_q    <= '0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      pf_valid_q  <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      incr_q      <= incr_d;
      wcnt_q      <= wcnt_d;
      hrdata_q    <= hrdata_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      pf_valid_q  <= pf_valid_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn && state_q == S_WDATA) mem[addr_q[MEM_AW-1:0]] <= HWDATA;
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule
